div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divide sequencer for the pipelined MIPS core. It owns the radix-2 restoring divider used by DIV/DIVU in the execute stage. It stalls the pipeline while an operation is in flight, honours flushes, and presents the 64-bit {HI,LO} result for the HI/LO write path. The controller drives `start` and `signed_div` from the decoded E-stage instruction. The hazard unit ORs `stall_div` into its F/D/E stall terms.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. The counter is $clog2(WIDTH) bits wide.

Ports:
- `clka` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: a DIV/DIVU is in E; held high by the pipeline while stalled.
- `signed_div` in 1: 1 = DIV (signed), 0 = DIVU. Sampled with `start` in IDLE.
- `annul` in 1: flush/exception cancel of the E-stage instruction.
- `opdata1` in WIDTH: dividend (rs). Sampled in IDLE.
- `opdata2` in WIDTH: divisor (rt). Sampled in IDLE.
- `stall_div` out 1: pipeline stall request.
- `ready` out 1: one-cycle pulse; `result` is valid this cycle.
- `result` out 2*WIDTH: {HI = remainder, LO = quotient}.

## Operation
States: IDLE, DIVBYZERO, ON, END.

IDLE:
- If `start` and not `annul`: capture the signs of both operands and `signed_div`.
- Load `|opdata1|` and `|opdata2|`; magnitudes are used only when signed, raw operands otherwise.
- Clear `cnt`.
- Next state is DIVBYZERO if `opdata2`==0, else ON.

ON:
- One restoring step per cycle on the working register {rem[WIDTH:0], quo[WIDTH-1:0]}.
- trial = {rem[WIDTH-1:0], quo[WIDTH-1]} − divisor, computed at WIDTH+1 bits.
- If trial is non-negative: rem ← trial, shift 1 into quo. Else: rem ← {rem[WIDTH-1:0], quo[WIDTH-1]}, shift 0 into quo.
- `cnt` increments each step. After the step with `cnt`==WIDTH−1, go to END.

DIVBYZERO:
- Load quo = all ones and rem = raw `opdata1` (no sign correction).
- Go to END.

END:
- Sign correction applies only to the ON path:
  - LO = −quo if signs differ, else quo.
  - HI = −rem if the dividend was negative, else rem.
- Register `result`; `ready`=1 for this cycle only.
- Always go to IDLE next cycle. A `start` still high in that IDLE cycle is a new instruction and launches a new divide.

Arithmetic corner: signed 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. The magnitude 0x80000000 is treated as unsigned; no trap.

`annul`:
- In any state, `annul`=1 forces next state IDLE.
- `ready` is not asserted and `result` is left unchanged.
- `stall_div` is forced to 0 combinationally while `annul`=1.

`result` holds its last value until the next END. Only END writes it.

## Timing
- Reset values: state=IDLE, `cnt`=0, working regs=0, `result`=0, `ready`=0, `stall_div`=0.
- `stall_div` = !annul & ((IDLE & start) | ON | DIVBYZERO). It is combinational from `start` in IDLE and is 0 in END.
- Normal divide: `stall_div` is high for 1+WIDTH consecutive cycles (33). `ready` pulses in the following cycle, cycle 34 counting the start cycle as 1.
- Divide by zero: `stall_div` is high for 2 cycles; `ready` is in cycle 3.
- `rst` asserted mid-operation: immediately IDLE with all outputs at reset values. No residual `ready`.
- `start` dropping mid-operation without `annul`: ignored; the operation completes.

## Structure
- Shared package `div_pkg`: state encoding localparams (IDLE, DIVBYZERO, ON, END) and the default `WIDTH`.
- One natural sub-module: `div_step`, purely combinational. It takes rem, quo and divisor and returns the next rem and quo for one restoring iteration.
- Sign handling and the FSM stay in `div_seq`.

## Test plan
- DIVU 100/7, `start` held until `ready` → `stall_div` high 33 cycles, `ready` cycle 34, HI=2, LO=14.
- DIV −7/2 (0xFFFFFFF9 / 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIV 7/−2 → LO=0xFFFFFFFD, HI=1.
- DIV 5/0 → `stall_div` 2 cycles, `ready` cycle 3, LO=0xFFFFFFFF, HI=5.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. DIVU 0xFFFFFFFF/1 → LO=0xFFFFFFFF, HI=0.
- `annul` pulsed when `cnt`==10 → `stall_div` 0 that cycle, IDLE next, no `ready`, `result` keeps prior value. A following DIVU 9/3 gives LO=3, HI=0.
- Back-to-back DIVU 20/6 then 21/4, with `start` high continuously → two `ready` pulses 34 cycles apart: {HI,LO}={2,3}, then {1,5}. Separately, `rst` asserted at `cnt`==5 → all outputs 0 immediately.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divide sequencer: default operand
// width and the controller state encoding.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_DIVBYZERO_ENC = 2'd1;
    localparam logic [1:0] ST_ON_ENC        = 2'd2;
    localparam logic [1:0] ST_END_ENC       = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE_ENC,
        S_DIVBYZERO = ST_DIVBYZERO_ENC,
        S_ON        = ST_ON_ENC,
        S_END       = ST_END_ENC
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, subtract the divisor, keep or restore.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The partial remainder stays below the divisor, so the top bit of the
    // restored (WIDTH+1)-bit remainder is always zero and is not carried.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer for the E stage: stalls the pipeline while the restoring
// divider iterates, applies sign correction and presents {HI,LO}.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clka,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic                 stall_div,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);

    div_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic              neg1_q, neg1_d;
    logic              neg2_q, neg2_d;
    logic              bz_q, bz_d;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]  step_rem, step_quo;
    logic              op1_neg, op2_neg;
    logic [WIDTH-1:0]  op1_mag, op2_mag;
    logic [WIDTH-1:0]  lo_fix, hi_fix, raw_dividend;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign op1_neg = signed_div & opdata1[WIDTH-1];
    assign op2_neg = signed_div & opdata2[WIDTH-1];
    assign op1_mag = op1_neg ? -opdata1 : opdata1;
    assign op2_mag = op2_neg ? -opdata2 : opdata2;

    // The dividend is held as a magnitude; negating again recovers the raw value.
    assign raw_dividend = neg1_q ? -quo_q : quo_q;

    assign lo_fix = ((neg1_q ^ neg2_q) & ~bz_q) ? -quo_q : quo_q;
    assign hi_fix = (neg1_q & ~bz_q) ? -rem_q : rem_q;

    // Handshake: start is a level request held by the pipeline; stall_div is
    // high while the request is in flight; ready pulses once with result valid
    // in the same cycle; annul cancels and drops the stall immediately.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        bz_d      = bz_q;
        stall_div = 1'b0;
        ready     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stall_div = 1'b1;
                    if (!annul) begin
                        neg1_d  = op1_neg;
                        neg2_d  = op2_neg;
                        quo_d   = op1_mag;
                        dvs_d   = op2_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        bz_d    = (opdata2 == '0);
                        state_d = (opdata2 == '0) ? S_DIVBYZERO : S_ON;
                    end
                end
            end
            S_ON: begin
                stall_div = 1'b1;
                rem_d     = step_rem;
                quo_d     = step_quo;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_END;
                end
            end
            S_DIVBYZERO: begin
                stall_div = 1'b1;
                quo_d     = '1;
                rem_d     = raw_dividend;
                state_d   = S_END;
            end
            S_END: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (annul) begin
            state_d   = S_IDLE;
            stall_div = 1'b0;
            ready     = 1'b0;
        end
        result = ready ? {hi_fix, lo_fix} : result_q;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            bz_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg1_q   <= neg1_d;
            neg2_q   <= neg2_d;
            bz_q     <= bz_d;
            result_q <= result;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed corner cases plus random DIV/DIVU traffic
// checked against an arithmetic reference model.
module tb_div_seq;

    localparam int W = 32;

    logic           clka = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic           annul;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic           stall_div;
    logic           ready;
    logic [2*W-1:0] result;

    int n_cmp = 0;
    int n_mis = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_res;

    div_seq #(.WIDTH(W)) dut (
        .clka       (clka),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .stall_div  (stall_div),
        .ready      (ready),
        .result     (result)
    );

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    // {HI,LO} from MIPS division rules using plain integer arithmetic.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
        return {r, q};
    endfunction

    // Issues one divide and follows it to its ready pulse. Starts on a fresh
    // cycle and returns just after a falling edge.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_res,
                           input int drop_at, input bit keep);
        int stalls = 0;
        int rdy_cyc = 0;
        logic [63:0] e;
        tick();
        exp_q.push_back(exp_res);
        start = 1'b1;
        signed_div = sgn;
        opdata1 = a;
        opdata2 = b;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clka);
            if (ready) begin
                rdy_cyc = c;
                break;
            end
            if (stall_div) stalls++;
            tick();
            if (c == drop_at) start = 1'b0;
        end
        e = exp_q.pop_front();
        check({tag, " ready_cycle"}, 64'(rdy_cyc), 64'((b == 32'd0) ? 3 : 34));
        check({tag, " stall_cycles"}, 64'(stalls), 64'((b == 32'd0) ? 2 : 33));
        check({tag, " stall_at_ready"}, 64'(stall_div), 64'd0);
        check({tag, " result"}, result, e);
        last_res = e;
        if (!keep) begin
            tick();
            start = 1'b0;
            @(negedge clka);
            check({tag, " ready_pulse_end"}, 64'(ready), 64'd0);
            check({tag, " result_hold"}, result, e);
        end
    endtask

    task automatic quiet_window(input string tag, input int cycles, input logic [63:0] hold);
        int rd = 0;
        int st = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            annul = 1'b0;
            @(negedge clka);
            if (ready) rd++;
            if (stall_div) st++;
        end
        check({tag, " no_ready"}, 64'(rd), 64'd0);
        check({tag, " no_stall"}, 64'(st), 64'd0);
        check({tag, " result_kept"}, result, hold);
    endtask

    initial begin
        logic        r_sgn;
        logic [31:0] r_a, r_b;
        int          sel;

        rst = 1'b1;
        start = 1'b0;
        signed_div = 1'b0;
        annul = 1'b0;
        opdata1 = '0;
        opdata2 = '0;
        last_res = '0;
        #2;
        check("reset ready", 64'(ready), 64'd0);
        check("reset stall", 64'(stall_div), 64'd0);
        check("reset result", result, 64'd0);
        @(posedge clka);
        @(posedge clka);
        @(negedge clka);
        rst = 1'b0;

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0, 1'b0);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 0, 1'b0);
        run_div("div_m7_0", 1'b1, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0, 1'b0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0, 1'b0);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 0, 1'b0);
        run_div("divu_drop_start", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 3, 1'b0);

        // Annul in the ON phase at cnt==10 (cycle 12 of the operation).
        tick();
        start = 1'b1;
        signed_div = 1'b0;
        opdata1 = 32'd1000;
        opdata2 = 32'd3;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clka);
            tick();
        end
        annul = 1'b1;
        start = 1'b0;
        @(negedge clka);
        check("annul stall", 64'(stall_div), 64'd0);
        check("annul ready", 64'(ready), 64'd0);
        quiet_window("after_annul", 40, last_res);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 1'b0);

        // Annul together with start in IDLE: no stall, nothing launched.
        tick();
        start = 1'b1;
        annul = 1'b1;
        opdata1 = 32'd77;
        opdata2 = 32'd5;
        @(negedge clka);
        check("idle_annul stall", 64'(stall_div), 64'd0);
        tick();
        start = 1'b0;
        annul = 1'b0;
        @(negedge clka);
        quiet_window("idle_annul", 40, last_res);

        run_div("b2b_20_6", 1'b0, 32'd20, 32'd6, {32'd2, 32'd3}, 0, 1'b1);
        run_div("b2b_21_4", 1'b0, 32'd21, 32'd4, {32'd1, 32'd5}, 0, 1'b0);

        // Asynchronous reset at cnt==5 (cycle 7 of the operation).
        tick();
        start = 1'b1;
        signed_div = 1'b0;
        opdata1 = 32'd50;
        opdata2 = 32'd5;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clka);
            tick();
        end
        #1;
        rst = 1'b1;
        start = 1'b0;
        #1;
        check("mid_rst stall", 64'(stall_div), 64'd0);
        check("mid_rst ready", 64'(ready), 64'd0);
        check("mid_rst result", result, 64'd0);
        @(negedge clka);
        rst = 1'b0;
        quiet_window("after_rst", 40, 64'd0);

        for (int k = 0; k < 16; k++) begin
            r_sgn = 1'($urandom_range(0, 1));
            r_a = $urandom;
            if ($urandom_range(0, 5) == 0) r_a = 32'h8000_0000;
            sel = $urandom_range(0, 7);
            case (sel)
                0: r_b = 32'd0;
                1: r_b = $urandom_range(1, 15);
                2: r_b = 32'hFFFF_FFFF;
                3: r_b = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: r_b = $urandom;
            endcase
            run_div($sformatf("rand%0d", k), r_sgn, r_a, r_b, model(r_sgn, r_a, r_b),
                    $urandom_range(0, 40), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
